l2_rx: RTL and testbench
========================

Name: l2_rx

Overview:
- L2 receive framer; sits between the SPI RX FIFO and the L3 command engine.
- Pops 32-bit words from the RX FIFO, hunts for the L2 sync, extracts the payload length and streams byte-swapped payload words to L3.
- Then holds off until l2_tx reports the response complete (l3_cmd_done), giving strict half-duplex command/response sequencing.

Parameters:
MAX_LEN, 16'd1024, largest legal payload length in bytes; larger frames are rejected.
TO_CYC, 16'd50000, idle cycles allowed between payload words before a timeout abort.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pin_l2_clr  in  1  synchronous clear: return to HUNT, drop the frame in progress
rx_fifo_empty  in  1  RX FIFO empty
rx_fifo_rd  out  1  RX FIFO pop; combinational, asserted only when !rx_fifo_empty
rx_fifo_dout  in  32  RX FIFO head word (first-word-fall-through, valid while !empty)
l3_start  out  1  one-cycle pulse: frame accepted, l3_len valid
l3_len  out  16  payload length in bytes, held until the next accepted frame
l3_wr_data  out  32  payload word, byte-swapped, invalid bytes zeroed
l3_wr_be  out  4  byte enables, bit 3 = byte in [31:24]
l3_wr_last  out  1  marks the final payload word
l3_wr_vld  out  1  payload word valid
l3_wr_rdy  in  1  L3 accepts the word
l3_cmd_done  in  1  pulse from l2_tx: response written, re-arm
l2_busy  out  1  high in every state except HUNT
frm_err  out  1  one-cycle error pulse
err_code  out  2  01 sync, 10 length, 11 timeout; held until the next error

Behaviour:
- Reset and pin_l2_clr: state HUNT; all outputs 0; counters 0. pin_l2_clr has priority over every other event, including an in-flight handshake.
- Header word layout: {len[15:0], 16'h55AA}.

HUNT:
- Pop a word whenever !rx_fifo_empty.
- dout[15:0] != 16'h55AA: discard the word; frm_err pulse with err_code 01 in the same cycle as the pop; stay in HUNT.
- Sync matches and len > MAX_LEN: err_code 10 pulse; stay in HUNT.
- Sync matches and len == 0: latch l3_len = 0; pulse l3_start the next cycle; go to WAIT_DONE.
- Otherwise: latch l3_len and rem = len; pulse l3_start the next cycle; go to DATA.

DATA:
- rx_fifo_rd = !rx_fifo_empty & (!l3_wr_vld | l3_wr_rdy). This is a single output register with no bubble, so 1 word/cycle throughput while L3 is ready.
- On each pop, load the output register:
  - l3_wr_data = {d[7:0], d[15:8], d[23:16], d[31:24]}.
  - Set l3_wr_vld.
  - last = (rem <= 4); rem <= last ? 0 : rem - 4.
- Byte enables on the last word, from rem[1:0]: 00 -> 1111, 01 -> 1000, 10 -> 1100, 11 -> 1110. Disabled bytes are forced to 0. Non-last words use 1111.
- l3_wr_vld drops on (vld & rdy) when no new pop occurs in that cycle.
- When the last word is accepted (vld & rdy & last): go to WAIT_DONE.
- Timeout: the counter resets on every pop and increments while rx_fifo_empty and no pop occurs.
  - Reaching TO_CYC: err_code 11 pulse; clear l3_wr_vld; go to HUNT. No l3_wr_last is issued.
  - The counter is frozen while a word is held in the output register awaiting l3_wr_rdy (L3 back-pressure is not a timeout).

WAIT_DONE:
- rx_fifo_rd = 0; incoming words stay in the FIFO.
- l3_cmd_done: go to HUNT.
- l3_cmd_done in any other state is ignored.

Simultaneous events:
- Error pulse together with l3_start: not possible by construction.
- l3_cmd_done in the same cycle as pin_l2_clr: clear wins (same target state).

Arithmetic:
- rem is 16 bit; no underflow because of the last-word clamp.
- Payload word count = ceil(len/4).

Decomposition:
- Package l2_pkg:
  - L2_SYNC = 16'h55AA
  - ERR_SYNC / ERR_LEN / ERR_TO codes
  - one-hot state encodings HUNT, DATA, WAIT_DONE
  - byte-enable lookup function from rem[1:0]
- One sub-module, l2_rx_tmo: TO_CYC down-counter with load/run/freeze inputs and an expiry pulse.

Test Plan:
- FIFO: 0x000955AA, 0x44332211, 0x88776655, 0x000000AA with rdy=1 -> l3_start with l3_len=9; words 0x11223344 be F, 0x55667788 be F, 0xAA000000 be 8 with last; busy until l3_cmd_done.
- Header 0x000055AA -> l3_start with l3_len=0, no l3_wr_vld, WAIT_DONE; a second header queued behind it is not popped until the l3_cmd_done pulse.
- Garbage 0x12345678 then a valid len=4 frame -> one frm_err (code 01), then normal frame delivery.
- Header 0x040155AA (len 1025) -> frm_err code 10, no l3_start, back to HUNT.
- len=8 frame with 1 data word, then FIFO empty for TO_CYC cycles (TO_CYC=16 in bench) -> frm_err code 11, HUNT, no last.
- len=12 frame with l3_wr_rdy toggled 1010…, plus pin_l2_clr asserted mid-stream in a second run -> no lost or duplicated words; clear returns to HUNT with all outputs 0 the next cycle.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared constants, state encodings and helpers for the L2 receive framer.
package l2_pkg;

  localparam logic [15:0] L2_SYNC  = 16'h55AA;

  localparam logic [1:0]  ERR_NONE = 2'b00;
  localparam logic [1:0]  ERR_SYNC = 2'b01;
  localparam logic [1:0]  ERR_LEN  = 2'b10;
  localparam logic [1:0]  ERR_TO   = 2'b11;

  typedef enum logic [2:0] {
    ST_HUNT = 3'b001,
    ST_DATA = 3'b010,
    ST_WAIT = 3'b100
  } l2_state_e;

  // Byte enables of the final payload word; bit 3 is the first payload byte.
  function automatic logic [3:0] be_lut(input logic [1:0] rem_lo);
    logic [3:0] be;
    case (rem_lo)
      2'b00:   be = 4'b1111;
      2'b01:   be = 4'b1000;
      2'b10:   be = 4'b1100;
      2'b11:   be = 4'b1110;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/l2_rx_tmo.sv
// Inter-word timeout: down-counter reloaded with TO_CYC, expires after
// TO_CYC consecutive run cycles.
module l2_rx_tmo #(
  parameter logic [15:0] TO_CYC = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic run_i,
  input  logic freeze_i,
  output logic expire_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: load beats freeze beats run; expiry on the last run cycle.
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (load_i) begin
      cnt_d = TO_CYC;
    end else if (freeze_i) begin
      cnt_d = cnt_q;
    end else if (run_i) begin
      if (cnt_q <= 16'd1) begin
        expire_o = 1'b1;
        cnt_d    = TO_CYC;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/l2_rx.sv
// L2 receive framer: hunts for the sync header, streams byte-swapped payload
// words to L3, then waits for the response to complete before re-arming.
module l2_rx
  import l2_pkg::*;
#(
  parameter logic [15:0] MAX_LEN = 16'd1024,
  parameter logic [15:0] TO_CYC  = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pin_l2_clr,
  input  logic        rx_fifo_empty,
  output logic        rx_fifo_rd,
  input  logic [31:0] rx_fifo_dout,
  output logic        l3_start,
  output logic [15:0] l3_len,
  output logic [31:0] l3_wr_data,
  output logic [3:0]  l3_wr_be,
  output logic        l3_wr_last,
  output logic        l3_wr_vld,
  input  logic        l3_wr_rdy,
  input  logic        l3_cmd_done,
  output logic        l2_busy,
  output logic        frm_err,
  output logic [1:0]  err_code
);

  l2_state_e   state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] len_q, len_d;
  logic        start_q, start_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic        last_q, last_d;
  logic        vld_q, vld_d;
  logic [1:0]  errc_q, errc_d;

  logic        rd_s;
  logic        acc_s;
  logic        hdr_bad_s;
  logic        frm_err_s;
  logic [1:0]  err_s;
  logic        tmo_exp_s;
  logic        last_s;
  logic [3:0]  be_s;
  logic [31:0] swap_s;
  logic [15:0] hdr_len_s;

  assign hdr_len_s = rx_fifo_dout[31:16];
  assign acc_s     = vld_q & l3_wr_rdy;
  assign swap_s    = {rx_fifo_dout[7:0], rx_fifo_dout[15:8],
                      rx_fifo_dout[23:16], rx_fifo_dout[31:24]};
  assign last_s    = (rem_q <= 16'd4);
  assign be_s      = last_s ? be_lut(rem_q[1:0]) : 4'b1111;

  // Pop decision; never pops while empty, during clear, or past the payload.
  always_comb begin
    rd_s = 1'b0;
    if (pin_l2_clr) begin
      rd_s = 1'b0;
    end else if (state_q == ST_HUNT) begin
      rd_s = !rx_fifo_empty;
    end else if (state_q == ST_DATA) begin
      rd_s = !rx_fifo_empty && (rem_q != 16'd0) && (!vld_q || l3_wr_rdy);
    end else begin
      rd_s = 1'b0;
    end
  end

  // Error classification for the word being popped, or the timeout.
  always_comb begin
    hdr_bad_s = 1'b0;
    err_s     = ERR_NONE;
    if ((state_q == ST_HUNT) && rd_s) begin
      if (rx_fifo_dout[15:0] != L2_SYNC) begin
        hdr_bad_s = 1'b1;
        err_s     = ERR_SYNC;
      end else if (hdr_len_s > MAX_LEN) begin
        hdr_bad_s = 1'b1;
        err_s     = ERR_LEN;
      end else begin
        hdr_bad_s = 1'b0;
      end
    end else if (tmo_exp_s) begin
      err_s = ERR_TO;
    end else begin
      err_s = ERR_NONE;
    end
    frm_err_s = hdr_bad_s | tmo_exp_s;
  end

  // Idle counter runs only while starved with an empty output register.
  l2_rx_tmo #(.TO_CYC(TO_CYC)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   ((state_q != ST_DATA) || rd_s || pin_l2_clr),
    .run_i    (rx_fifo_empty),
    .freeze_i (vld_q),
    .expire_o (tmo_exp_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides every other event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT: begin
        if (rd_s && !hdr_bad_s) begin
          state_d = (hdr_len_s == 16'd0) ? ST_WAIT : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tmo_exp_s) begin
          state_d = ST_HUNT;
        end else if (acc_s && last_q) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (l3_cmd_done) begin
          state_d = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase
    if (pin_l2_clr) begin
      state_d = ST_HUNT;
    end
  end

  // Output/datapath next values: header latch, payload register, error code.
  always_comb begin
    rem_d   = rem_q;
    len_d   = len_q;
    start_d = 1'b0;
    data_d  = data_q;
    be_d    = be_q;
    last_d  = last_q;
    vld_d   = vld_q;
    errc_d  = errc_q;
    if (pin_l2_clr) begin
      rem_d  = 16'd0;
      len_d  = 16'd0;
      data_d = 32'd0;
      be_d   = 4'd0;
      last_d = 1'b0;
      vld_d  = 1'b0;
      errc_d = ERR_NONE;
    end else begin
      if (frm_err_s) begin
        errc_d = err_s;
      end
      if ((state_q == ST_HUNT) && rd_s && !hdr_bad_s) begin
        start_d = 1'b1;
        len_d   = hdr_len_s;
        rem_d   = hdr_len_s;
      end else if ((state_q == ST_DATA) && rd_s) begin
        vld_d  = 1'b1;
        last_d = last_s;
        be_d   = be_s;
        rem_d  = last_s ? 16'd0 : rem_q - 16'd4;
        for (int i = 0; i < 4; i++) begin
          data_d[8*i +: 8] = be_s[i] ? swap_s[8*i +: 8] : 8'h00;
        end
      end else if ((state_q == ST_DATA) && (acc_s || tmo_exp_s)) begin
        vld_d  = 1'b0;
        last_d = 1'b0;
      end
    end
  end

  // Registered outputs and frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= 16'd0;
      len_q   <= 16'd0;
      start_q <= 1'b0;
      data_q  <= 32'd0;
      be_q    <= 4'd0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
      errc_q  <= ERR_NONE;
    end else begin
      rem_q   <= rem_d;
      len_q   <= len_d;
      start_q <= start_d;
      data_q  <= data_d;
      be_q    <= be_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      errc_q  <= errc_d;
    end
  end

  assign rx_fifo_rd = rd_s;
  assign l3_start   = start_q;
  assign l3_len     = len_q;
  assign l3_wr_data = data_q;
  assign l3_wr_be   = be_q;
  assign l3_wr_last = last_q;
  assign l3_wr_vld  = vld_q;
  assign l2_busy    = (state_q != ST_HUNT);
  assign frm_err    = frm_err_s;
  assign err_code   = frm_err_s ? err_s : errc_q;

endmodule

// File: tb/tb_l2_rx.sv
// Directed bench for l2_rx: FIFO model, L3 sink monitor, one task per scenario.
module tb_l2_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pin_l2_clr = 1'b0;
  logic        rx_fifo_empty = 1'b1;
  logic        rx_fifo_rd;
  logic [31:0] rx_fifo_dout = 32'd0;
  logic        l3_start;
  logic [15:0] l3_len;
  logic [31:0] l3_wr_data;
  logic [3:0]  l3_wr_be;
  logic        l3_wr_last;
  logic        l3_wr_vld;
  logic        l3_wr_rdy = 1'b1;
  logic        l3_cmd_done = 1'b0;
  logic        l2_busy;
  logic        frm_err;
  logic [1:0]  err_code;

  int checks = 0;
  int failures = 0;

  logic [31:0] fifo[$];
  logic [31:0] rcv_data[$];
  logic [3:0]  rcv_be[$];
  logic        rcv_last[$];
  int          n_start, n_err, step_no, acc_step, err_step;
  logic [15:0] start_len;
  logic [1:0]  last_errc;

  l2_rx #(.MAX_LEN(16'd1024), .TO_CYC(16'd16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pin_l2_clr    (pin_l2_clr),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_rd    (rx_fifo_rd),
    .rx_fifo_dout  (rx_fifo_dout),
    .l3_start      (l3_start),
    .l3_len        (l3_len),
    .l3_wr_data    (l3_wr_data),
    .l3_wr_be      (l3_wr_be),
    .l3_wr_last    (l3_wr_last),
    .l3_wr_vld     (l3_wr_vld),
    .l3_wr_rdy     (l3_wr_rdy),
    .l3_cmd_done   (l3_cmd_done),
    .l2_busy       (l2_busy),
    .frm_err       (frm_err),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  task automatic fifo_upd();
    rx_fifo_empty = (fifo.size() == 0);
    rx_fifo_dout  = rx_fifo_empty ? 32'd0 : fifo[0];
  endtask

  task automatic push(input logic [31:0] w);
    fifo.push_back(w);
    fifo_upd();
  endtask

  task automatic clr_mon();
    rcv_data.delete();
    rcv_be.delete();
    rcv_last.delete();
    n_start = 0;
    n_err = 0;
    start_len = 16'd0;
    last_errc = 2'b00;
    acc_step = 0;
    err_step = 0;
  endtask

  // One clock: sample pre-edge activity, advance, then apply the FIFO pop.
  task automatic step();
    logic pop;
    #1;
    step_no++;
    if (l3_wr_vld && l3_wr_rdy) begin
      rcv_data.push_back(l3_wr_data);
      rcv_be.push_back(l3_wr_be);
      rcv_last.push_back(l3_wr_last);
      acc_step = step_no;
    end
    if (frm_err) begin
      n_err++;
      last_errc = err_code;
      err_step = step_no;
    end
    if (l3_start) begin
      n_start++;
      start_len = l3_len;
    end
    pop = rx_fifo_rd;
    @(posedge clk);
    #1;
    if (pop && fifo.size() > 0) void'(fifo.pop_front());
    fifo_upd();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cmd_done();
    l3_cmd_done = 1'b1;
    step();
    l3_cmd_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
    step();
    checks++; if (l2_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", l2_busy); end
    checks++; if (l3_wr_vld !== 1'b0 || l3_start !== 1'b0 || l3_wr_last !== 1'b0) begin failures++; $display("FAIL reset_ctrl got=%b%b%b exp=000", l3_wr_vld, l3_start, l3_wr_last); end
    checks++; if (l3_len !== 16'd0 || err_code !== 2'b00 || frm_err !== 1'b0) begin failures++; $display("FAIL reset_len_err got=%h/%b/%b exp=0/00/0", l3_len, err_code, frm_err); end
    checks++; if (l3_wr_data !== 32'd0 || l3_wr_be !== 4'd0 || rx_fifo_rd !== 1'b0) begin failures++; $display("FAIL reset_data got=%h/%h/%b exp=0/0/0", l3_wr_data, l3_wr_be, rx_fifo_rd); end
  endtask

  task automatic test_basic_frame();
    logic [31:0] ed [3];
    logic [3:0]  eb [3];
    ed[0] = 32'h11223344; ed[1] = 32'h55667788; ed[2] = 32'hAA000000;
    eb[0] = 4'hF; eb[1] = 4'hF; eb[2] = 4'h8;
    clr_mon();
    l3_wr_rdy = 1'b1;
    push(32'h000955AA); push(32'h44332211); push(32'h88776655); push(32'h000000AA);
    steps(8);
    checks++; if (n_start !== 1 || start_len !== 16'd9) begin failures++; $display("FAIL basic_start got=%0d/%0d exp=1/9", n_start, start_len); end
    checks++; if (rcv_data.size() !== 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", rcv_data.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < rcv_data.size()) begin
        checks++;
        if (rcv_data[i] !== ed[i] || rcv_be[i] !== eb[i] || rcv_last[i] !== (i == 2)) begin
          failures++;
          $display("FAIL basic_word%0d got=%h/%h/%b exp=%h/%h/%b", i, rcv_data[i], rcv_be[i], rcv_last[i], ed[i], eb[i], (i == 2));
        end
      end
    end
    checks++; if (l2_busy !== 1'b1 || l3_wr_vld !== 1'b0) begin failures++; $display("FAIL basic_wait got=%b/%b exp=1/0", l2_busy, l3_wr_vld); end
    cmd_done();
    checks++; if (l2_busy !== 1'b0) begin failures++; $display("FAIL basic_done got=%b exp=0", l2_busy); end
  endtask

  task automatic test_zero_len();
    clr_mon();
    push(32'h000055AA); push(32'h000455AA);
    steps(5);
    checks++; if (n_start !== 1 || start_len !== 16'd0 || rcv_data.size() !== 0) begin failures++; $display("FAIL zero_start got=%0d/%0d/%0d exp=1/0/0", n_start, start_len, rcv_data.size()); end
    checks++; if (l2_busy !== 1'b1 || fifo.size() !== 1 || rx_fifo_rd !== 1'b0) begin failures++; $display("FAIL zero_hold got=%b/%0d/%b exp=1/1/0", l2_busy, fifo.size(), rx_fifo_rd); end
    cmd_done();
    checks++; if (l2_busy !== 1'b0 || fifo.size() !== 1) begin failures++; $display("FAIL zero_rearm got=%b/%0d exp=0/1", l2_busy, fifo.size()); end
    push(32'hDDCCBBAA);
    steps(5);
    checks++; if (n_start !== 2 || start_len !== 16'd4 || rcv_data.size() !== 1) begin failures++; $display("FAIL zero_next got=%0d/%0d/%0d exp=2/4/1", n_start, start_len, rcv_data.size()); end
    if (rcv_data.size() > 0) begin
      checks++; if (rcv_data[0] !== 32'hAABBCCDD || rcv_be[0] !== 4'hF || rcv_last[0] !== 1'b1) begin failures++; $display("FAIL zero_word got=%h/%h/%b exp=aabbccdd/f/1", rcv_data[0], rcv_be[0], rcv_last[0]); end
    end
    cmd_done();
  endtask

  task automatic test_garbage();
    clr_mon();
    push(32'h12345678); push(32'h000455AA); push(32'h04030201);
    steps(8);
    checks++; if (n_err !== 1 || last_errc !== 2'b01) begin failures++; $display("FAIL garbage_err got=%0d/%b exp=1/01", n_err, last_errc); end
    checks++; if (n_start !== 1 || start_len !== 16'd4 || rcv_data.size() !== 1) begin failures++; $display("FAIL garbage_frame got=%0d/%0d/%0d exp=1/4/1", n_start, start_len, rcv_data.size()); end
    if (rcv_data.size() > 0) begin
      checks++; if (rcv_data[0] !== 32'h01020304 || rcv_last[0] !== 1'b1) begin failures++; $display("FAIL garbage_word got=%h/%b exp=01020304/1", rcv_data[0], rcv_last[0]); end
    end
    checks++; if (err_code !== 2'b01) begin failures++; $display("FAIL garbage_hold got=%b exp=01", err_code); end
    cmd_done();
  endtask

  task automatic test_len_err();
    clr_mon();
    push(32'h040155AA);
    steps(3);
    checks++; if (n_err !== 1 || last_errc !== 2'b10 || n_start !== 0 || l2_busy !== 1'b0) begin failures++; $display("FAIL len_err got=%0d/%b/%0d/%b exp=1/10/0/0", n_err, last_errc, n_start, l2_busy); end
    clr_mon();
    push(32'h040055AA); push(32'hCAFEF00D);
    steps(3);
    checks++; if (n_start !== 1 || start_len !== 16'd1024 || n_err !== 0 || l2_busy !== 1'b1) begin failures++; $display("FAIL len_max got=%0d/%0d/%0d/%b exp=1/1024/0/1", n_start, start_len, n_err, l2_busy); end
    checks++; if (rcv_data.size() !== 1 || (rcv_data.size() == 1 && (rcv_data[0] !== 32'h0DF0FECA || rcv_last[0] !== 1'b0))) begin failures++; $display("FAIL len_max_word got=%0d exp=1 word 0df0feca not last", rcv_data.size()); end
    pin_l2_clr = 1'b1;
    step();
    pin_l2_clr = 1'b0;
    checks++; if (l2_busy !== 1'b0 || l3_len !== 16'd0) begin failures++; $display("FAIL len_clr got=%b/%0d exp=0/0", l2_busy, l3_len); end
  endtask

  task automatic test_timeout();
    clr_mon();
    push(32'h000855AA); push(32'h11111111);
    for (int i = 0; i < 40; i++) begin
      if (n_err == 0) step();
    end
    checks++; if (n_err !== 1 || last_errc !== 2'b11) begin failures++; $display("FAIL tmo_err got=%0d/%b exp=1/11", n_err, last_errc); end
    checks++; if (err_step - acc_step !== 16) begin failures++; $display("FAIL tmo_delay got=%0d exp=16", err_step - acc_step); end
    checks++; if (rcv_data.size() !== 1 || (rcv_data.size() == 1 && rcv_last[0] !== 1'b0)) begin failures++; $display("FAIL tmo_nolast got=%0d exp=1 word not last", rcv_data.size()); end
    checks++; if (l2_busy !== 1'b0 || l3_wr_vld !== 1'b0) begin failures++; $display("FAIL tmo_hunt got=%b/%b exp=0/0", l2_busy, l3_wr_vld); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ed [3];
    ed[0] = 32'h00010203; ed[1] = 32'h04050607; ed[2] = 32'h08090A0B;
    clr_mon();
    push(32'h000C55AA); push(32'h03020100); push(32'h07060504); push(32'h0B0A0908);
    for (int i = 0; i < 20; i++) begin
      l3_wr_rdy = (i % 2 == 0);
      step();
    end
    checks++; if (rcv_data.size() !== 3 || n_err !== 0) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=3/0", rcv_data.size(), n_err); end
    for (int i = 0; i < 3; i++) begin
      if (i < rcv_data.size()) begin
        checks++;
        if (rcv_data[i] !== ed[i] || rcv_be[i] !== 4'hF || rcv_last[i] !== (i == 2)) begin
          failures++;
          $display("FAIL bp_word%0d got=%h/%h/%b exp=%h/f/%b", i, rcv_data[i], rcv_be[i], rcv_last[i], ed[i], (i == 2));
        end
      end
    end
    cmd_done();
    // Second run: clear mid-stream while a word is being handed over.
    clr_mon();
    push(32'h000C55AA); push(32'h03020100); push(32'h07060504); push(32'h0B0A0908);
    for (int i = 0; i < 4; i++) begin
      l3_wr_rdy = (i % 2 == 0);
      step();
    end
    fifo.delete();
    fifo_upd();
    pin_l2_clr = 1'b1;
    l3_wr_rdy = 1'b1;
    step();
    pin_l2_clr = 1'b0;
    l3_wr_rdy = 1'b0;
    #1;
    checks++; if (l3_start !== 1'b0 || l3_len !== 16'd0 || l3_wr_vld !== 1'b0 || l3_wr_last !== 1'b0) begin failures++; $display("FAIL clr_ctrl got=%b/%0d/%b/%b exp=0/0/0/0", l3_start, l3_len, l3_wr_vld, l3_wr_last); end
    checks++; if (l3_wr_data !== 32'd0 || l3_wr_be !== 4'd0 || l2_busy !== 1'b0) begin failures++; $display("FAIL clr_data got=%h/%h/%b exp=0/0/0", l3_wr_data, l3_wr_be, l2_busy); end
    checks++; if (frm_err !== 1'b0 || err_code !== 2'b00 || rx_fifo_rd !== 1'b0) begin failures++; $display("FAIL clr_err got=%b/%b/%b exp=0/00/0", frm_err, err_code, rx_fifo_rd); end
    checks++; if (rcv_data.size() !== 2) begin failures++; $display("FAIL clr_count got=%0d exp=2", rcv_data.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < rcv_data.size()) begin
        checks++;
        if (rcv_data[i] !== ed[i]) begin
          failures++;
          $display("FAIL clr_word%0d got=%h exp=%h", i, rcv_data[i], ed[i]);
        end
      end
    end
  endtask

  initial begin
    step_no = 0;
    clr_mon();
    test_reset();
    test_basic_frame();
    test_zero_len();
    test_garbage();
    test_len_err();
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
